// File: rtl/pio_hs_ctrl.sv
// Four-phase PIO handshake controller bridging Nios SW and the video datapath via TX/RX FIFOs.
// Optional handshake watchdog enabled by defining HS_TIMEOUT_EN.
`timescale 1ns/1ps
module pio_hs_ctrl #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] sw_cmd_data,
  input  logic [7:0]        sw_cmd_sig,
  output logic [DATA_W-1:0] sw_rsp_data,
  output logic [7:0]        sw_rsp_sig,
  output logic [DATA_W-1:0] dp_tx_data,
  output logic              dp_tx_valid,
  input  logic              dp_tx_ready,
  input  logic [DATA_W-1:0] dp_rx_data,
  input  logic              dp_rx_valid,
  output logic              dp_rx_ready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  typedef logic [AW:0] ptr_t;

  typedef enum logic {TX_IDLE, TX_ACK} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_WAIT, RX_DONE} rx_state_t;

  tx_state_t r_tx_state, w_tx_nxt;
  rx_state_t r_rx_state, w_rx_nxt;

  logic [DATA_W-1:0] r_tx_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] r_rx_mem [FIFO_DEPTH];
  ptr_t r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
  ptr_t w_tx_wr_n, w_tx_rd_n, w_rx_wr_n, w_rx_rd_n;

  logic [DATA_W-1:0] r_rsp_data;
  logic r_tx_valid, r_tx_full, r_rx_ne, r_rx_full, r_rx_rdy;
  logic r_proto_err, r_tmo_err;

  logic w_req, w_rdack, w_clr;
  logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic w_tx_full, w_rx_empty, w_proto;
  logic w_tx_tmo, w_rx_tmo, w_tx_blk;
  logic w_unused;

  assign w_req    = sw_cmd_sig[0];
  assign w_rdack  = sw_cmd_sig[1];
  assign w_clr    = sw_cmd_sig[7];
  assign w_unused = ^sw_cmd_sig[6:2];

  assign w_tx_full  = (ptr_t'(r_tx_wr - r_tx_rd) == ptr_t'(FIFO_DEPTH));
  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_tx_pop   = r_tx_valid && dp_tx_ready && !w_clr;
  assign w_rx_push  = dp_rx_valid && r_rx_rdy && !w_clr;
  assign w_proto    = (r_rx_state == RX_IDLE) && w_rdack;

  always_comb begin
    w_tx_nxt  = r_tx_state;
    w_tx_push = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (w_req && !w_tx_full && !w_tx_blk) begin
        w_tx_push = 1'b1;
        w_tx_nxt  = TX_ACK;
      end
      TX_ACK:  if (!w_req || w_tx_tmo) w_tx_nxt = TX_IDLE;
      default: w_tx_nxt = TX_IDLE;
    endcase
    if (w_clr) begin
      w_tx_nxt  = TX_IDLE;
      w_tx_push = 1'b0;
    end
  end

  always_comb begin
    w_rx_nxt = r_rx_state;
    w_rx_pop = 1'b0;
    case (r_rx_state)
      RX_IDLE: if (!w_rx_empty) begin
        w_rx_pop = 1'b1;
        w_rx_nxt = RX_WAIT;
      end
      RX_WAIT: if (w_rdack) w_rx_nxt = RX_DONE;
               else if (w_rx_tmo) w_rx_nxt = RX_IDLE;
      RX_DONE: if (!w_rdack || w_rx_tmo) w_rx_nxt = RX_IDLE;
      default: w_rx_nxt = RX_IDLE;
    endcase
    if (w_clr) begin
      w_rx_nxt = RX_IDLE;
      w_rx_pop = 1'b0;
    end
  end

  assign w_tx_wr_n = w_clr ? '0 : ptr_t'(r_tx_wr + ptr_t'(w_tx_push));
  assign w_tx_rd_n = w_clr ? '0 : ptr_t'(r_tx_rd + ptr_t'(w_tx_pop));
  assign w_rx_wr_n = w_clr ? '0 : ptr_t'(r_rx_wr + ptr_t'(w_rx_push));
  assign w_rx_rd_n = w_clr ? '0 : ptr_t'(r_rx_rd + ptr_t'(w_rx_pop));

  always_ff @(posedge clk_clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[AW-1:0]] <= sw_cmd_data;
    if (w_rx_push) r_rx_mem[r_rx_wr[AW-1:0]] <= dp_rx_data;
  end

  // Status flags are registered from the next pointer values so they match post-edge FIFO state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tx_state  <= TX_IDLE;
      r_rx_state  <= RX_IDLE;
      r_tx_wr     <= '0;
      r_tx_rd     <= '0;
      r_rx_wr     <= '0;
      r_rx_rd     <= '0;
      r_rsp_data  <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_full   <= 1'b0;
      r_rx_ne     <= 1'b0;
      r_rx_full   <= 1'b0;
      r_rx_rdy    <= 1'b0;
      r_proto_err <= 1'b0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_tx_state  <= w_tx_nxt;
      r_rx_state  <= w_rx_nxt;
      r_tx_wr     <= w_tx_wr_n;
      r_tx_rd     <= w_tx_rd_n;
      r_rx_wr     <= w_rx_wr_n;
      r_rx_rd     <= w_rx_rd_n;
      if (w_rx_pop) r_rsp_data <= r_rx_mem[r_rx_rd[AW-1:0]];
      r_tx_valid  <= (w_tx_wr_n != w_tx_rd_n);
      r_tx_full   <= (ptr_t'(w_tx_wr_n - w_tx_rd_n) == ptr_t'(FIFO_DEPTH));
      r_rx_ne     <= (w_rx_wr_n != w_rx_rd_n);
      r_rx_full   <= (ptr_t'(w_rx_wr_n - w_rx_rd_n) == ptr_t'(FIFO_DEPTH));
      r_rx_rdy    <= (ptr_t'(w_rx_wr_n - w_rx_rd_n) != ptr_t'(FIFO_DEPTH));
      r_proto_err <= w_clr ? 1'b0 : (r_proto_err | w_proto);
      r_tmo_err   <= w_clr ? 1'b0 : (r_tmo_err | w_tx_tmo | w_rx_tmo);
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] r_tx_cnt, r_rx_cnt;
  logic          r_tx_blk;

  assign w_tx_tmo = (r_tx_state == TX_ACK)  && (r_tx_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_rx_tmo = (r_rx_state != RX_IDLE) && (r_rx_cnt == TW'(TIMEOUT_CYC - 1));
  assign w_tx_blk = r_tx_blk;

  // After a TX timeout a still-held REQ must drop before a new write is accepted.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_tx_blk <= 1'b0;
    end else begin
      r_tx_cnt <= (w_tx_nxt != r_tx_state || r_tx_state == TX_IDLE) ? '0 : r_tx_cnt + TW'(1);
      r_rx_cnt <= (w_rx_nxt != r_rx_state || r_rx_state == RX_IDLE) ? '0 : r_rx_cnt + TW'(1);
      if (w_clr || !w_req) r_tx_blk <= 1'b0;
      else if (w_tx_tmo)   r_tx_blk <= 1'b1;
    end
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYC);
  assign w_tx_tmo = 1'b0;
  assign w_rx_tmo = 1'b0;
  assign w_tx_blk = 1'b0;
`endif

  assign sw_rsp_data = r_rsp_data;
  assign sw_rsp_sig  = {1'b0, r_tmo_err, r_proto_err, r_rx_full, r_rx_ne, r_tx_full,
                        (r_rx_state == RX_WAIT), (r_tx_state == TX_ACK)};
  assign dp_tx_data  = r_tx_mem[r_tx_rd[AW-1:0]];
  assign dp_tx_valid = r_tx_valid;
  assign dp_rx_ready = r_rx_rdy;

endmodule
